commit_trace_fifo: RTL and testbench
====================================

# commit_trace_fifo

Retire-side consumer for the CPU's commit stream. Captures every instruction the reorder buffer retires (destination register, result, PC, mispredict flag) into a small FIFO. Drains entries to a debug/trace reader over a valid/ready handshake. Sits beside the CPU top level on the ROB commit bus and gives verification and bring-up an architectural retirement log that tolerates reader back-pressure.

## Interface
Parameters:
- WIDTH, 31: MSB index of data/PC words (32-bit).
- REG, 4: MSB index of register number (32 registers).
- DEPTH_LOG, 3: log2 of FIFO depth (8 entries).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- globalReset  in  1  synchronous, active-high reset.
- commitValid  in  1  ROB retires one instruction this cycle.
- destCommit  in  REG+1  destination register of the retiring instruction.
- result  in  WIDTH+1  committed result value.
- commitPC  in  WIDTH+1  PC of the retiring instruction.
- mispredict  in  1  retiring instruction redirected control flow (ROB controlFlow[0]).
- traceReady  in  1  reader accepts the head entry.
- clearOverflow  in  1  clears overflow and dropCount.
- traceValid  out  1  head entry present (count != 0).
- traceDest  out  REG+1  head entry register.
- traceResult  out  WIDTH+1  head entry result.
- tracePC  out  WIDTH+1  head entry PC.
- traceFlush  out  1  head entry was a mispredict.
- count  out  DEPTH_LOG+1  occupied entries, 0..2^DEPTH_LOG.
- overflow  out  1  sticky: at least one commit dropped.
- dropCount  out  16  dropped commits, saturating at 16'hFFFF.

## Operation
- pop = traceValid && traceReady. push = commitValid && (count < 2^DEPTH_LOG || pop).
- Push writes {destCommit, result, commitPC, mispredict} at wrPtr, then wrPtr++. Pop advances rdPtr++. Both pointers are DEPTH_LOG bits and wrap modulo 2^DEPTH_LOG.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Full (count = 2^DEPTH_LOG) with pop in the same cycle: push is accepted.
- Full, commitValid = 1, no pop: drop occurs. Entry is discarded, overflow is set, and dropCount increments, saturating at 16'hFFFF.
- Empty, commitValid = 1: push only. A pop is impossible because traceValid = 0, so there is no write-through bypass.
- clearOverflow with no drop in the same cycle: overflow := 0, dropCount := 0. With a drop in the same cycle: overflow := 1, dropCount := 1.
- The trace outputs show the head entry combinationally from storage at rdPtr. When traceValid = 0 they are don't-care; the bench checks them only while valid.
- Reset: wrPtr, rdPtr, count, overflow and dropCount all go to 0. Hence traceValid = 0. Storage contents are not reset.
- Reset asserted mid-stream discards all entries. A commit in the reset cycle is not captured.

## Timing
- Push in cycle N: entry visible on trace outputs and traceValid = 1 in cycle N+1, provided it is the head.
- Pop in cycle N: next entry, or traceValid = 0, in cycle N+1.
- Sustained throughput is one commit per cycle when traceReady is held high. There are no bubbles.
- The reader may hold traceReady low indefinitely. The head entry and traceValid must remain stable until popped.
- overflow and dropCount update in the cycle after the drop.

## Structure
- Package riscv_trace_pkg holds:
  - typedef trace_entry_t (dest, result, pc, flush);
  - the DEPTH_LOG default;
  - the DROP_MAX = 16'hFFFF constant.
- Sub-module trace_fifo_mem: 2^DEPTH_LOG × trace_entry_t register array, one write port, one asynchronous read port. The top level owns pointers, count, handshake and overflow logic.

## Test plan
- Reset then single commit (dest 5, result 32'hDEADBEEF, PC 32'h40), traceReady = 0: next cycle traceValid = 1, count = 1, outputs match. They stay stable for 10 cycles, then pop → traceValid = 0.
- Back-to-back 20 commits with traceReady = 1 throughout: 20 entries out in order, PCs 0,4,…,76, count ≤ 1, overflow = 0.
- Fill 8 entries with traceReady = 0, then 3 more commits: count = 8, overflow = 1, dropCount = 3. Draining yields the first 8 entries only.
- Full FIFO with simultaneous commit and pop: count stays 8, new entry appears 8th in the drain order, no drop.
- Drop and clearOverflow in the same cycle: overflow = 1, dropCount = 1. A later clear alone gives overflow = 0, dropCount = 0.
- 5 entries queued (one with mispredict = 1, traceFlush checked), then globalReset for 1 cycle: count = 0, traceValid = 0. The following commit is the first entry out.

Source files
------------

// File: rtl/commit_trace_fifo_pkg.sv
// Shared types and constants for the retirement trace FIFO.
package riscv_trace_pkg;
    localparam int WIDTH_DEF     = 31;
    localparam int REG_DEF       = 4;
    localparam int DEPTH_LOG_DEF = 3;
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef struct packed {
        logic [REG_DEF:0]   dest;
        logic [WIDTH_DEF:0] result;
        logic [WIDTH_DEF:0] pc;
        logic               flush;
    } trace_entry_t;
endpackage

// File: rtl/commit_trace_fifo_if.sv
// Commit-side and trace-side signal bundle; master drives commits/reader, slave is the FIFO.
interface commit_trace_fifo_if #(
    parameter int WIDTH     = 31,
    parameter int REG       = 4,
    parameter int DEPTH_LOG = 3
);
    logic               commitValid;
    logic [REG:0]       destCommit;
    logic [WIDTH:0]     result;
    logic [WIDTH:0]     commitPC;
    logic               mispredict;
    logic               traceReady;
    logic               clearOverflow;
    logic               traceValid;
    logic [REG:0]       traceDest;
    logic [WIDTH:0]     traceResult;
    logic [WIDTH:0]     tracePC;
    logic               traceFlush;
    logic [DEPTH_LOG:0] count;
    logic               overflow;
    logic [15:0]        dropCount;

    modport master (
        output commitValid, destCommit, result, commitPC, mispredict,
        output traceReady, clearOverflow,
        input  traceValid, traceDest, traceResult, tracePC, traceFlush,
        input  count, overflow, dropCount
    );

    modport slave (
        input  commitValid, destCommit, result, commitPC, mispredict,
        input  traceReady, clearOverflow,
        output traceValid, traceDest, traceResult, tracePC, traceFlush,
        output count, overflow, dropCount
    );
endinterface

// File: rtl/commit_trace_fifo_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module trace_fifo_mem
    import riscv_trace_pkg::*;
#(
    parameter int  DEPTH_LOG = DEPTH_LOG_DEF,
    parameter type entry_t   = trace_entry_t
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_LOG-1:0] waddr,
    input  entry_t               wdata,
    input  logic [DEPTH_LOG-1:0] raddr,
    output entry_t               rdata
);
    entry_t mem [2**DEPTH_LOG];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/commit_trace_fifo.sv
// Captures ROB retirements into a small FIFO and drains them to a trace reader,
// counting commits lost while the FIFO is full and the reader stalls.
module commit_trace_fifo
    import riscv_trace_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int REG       = REG_DEF,
    parameter int DEPTH_LOG = DEPTH_LOG_DEF
) (
    input  logic                clk,
    input  logic                globalReset,
    commit_trace_fifo_if.slave  bus
);
    localparam int CNT_W = DEPTH_LOG + 1;
    localparam logic [CNT_W-1:0] CAP = CNT_W'(1 << DEPTH_LOG);

    typedef struct packed {
        logic [REG:0]   dest;
        logic [WIDTH:0] result;
        logic [WIDTH:0] pc;
        logic           flush;
    } entry_t;

    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [CNT_W-1:0]     occ;
    logic                 ovf;
    logic [15:0]          drops;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    entry_t               wr_entry;
    entry_t               head;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    always_comb begin
        full           = (occ == CAP);
        pop            = (occ != '0) && bus.traceReady;
        push           = bus.commitValid && (!full || pop);
        drop           = bus.commitValid && full && !pop;
        wr_entry       = '0;
        wr_entry.dest   = bus.destCommit;
        wr_entry.result = bus.result;
        wr_entry.pc     = bus.commitPC;
        wr_entry.flush  = bus.mispredict;
    end

    always_ff @(posedge clk) begin
        if (globalReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ovf    <= 1'b0;
            drops  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + CNT_W'(push) - CNT_W'(pop);
            // A drop coinciding with a clear is counted as the first new drop.
            if (bus.clearOverflow) begin
                ovf   <= drop;
                drops <= drop ? 16'd1 : 16'd0;
            end else if (drop) begin
                ovf <= 1'b1;
                if (drops != DROP_MAX) drops <= drops + 16'd1;
            end
        end
    end

    trace_fifo_mem #(
        .DEPTH_LOG (DEPTH_LOG),
        .entry_t   (entry_t)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign bus.traceValid  = (occ != '0);
    assign bus.traceDest   = head.dest;
    assign bus.traceResult = head.result;
    assign bus.tracePC     = head.pc;
    assign bus.traceFlush  = head.flush;
    assign bus.count       = occ;
    assign bus.overflow    = ovf;
    assign bus.dropCount   = drops;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// Randomised and directed scoreboard bench for commit_trace_fifo against a queue-based model.
module tb_commit_trace_fifo;
    localparam int CAPACITY = 8;

    logic clk = 1'b0;
    logic globalReset;
    always #5 clk = ~clk;

    commit_trace_fifo_if #(.WIDTH(31), .REG(4), .DEPTH_LOG(3)) bus ();

    commit_trace_fifo #(.WIDTH(31), .REG(4), .DEPTH_LOG(3)) dut (
        .clk         (clk),
        .globalReset (globalReset),
        .bus         (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: entries held, sticky flag, drop counter.
    logic [69:0] model_q[$];
    logic        m_ovf   = 1'b0;
    logic [15:0] m_drops = '0;
    logic        known   = 1'b0;

    // Expected DUT state during the current cycle, and popped entries awaiting check.
    logic [69:0] exp_q[$];
    logic        mon_en    = 1'b0;
    logic        exp_valid = 1'b0;
    int          exp_cnt   = 0;
    logic        exp_ovf   = 1'b0;
    logic [15:0] exp_drops = '0;
    logic [69:0] exp_head  = '0;

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic cv, input logic [4:0] d, input logic [31:0] r,
                        input logic [31:0] pc, input logic mp, input logic rdy,
                        input logic clr, input logic rs);
        logic pop, accept, drop;
        @(posedge clk);
        #1;
        globalReset       = rs;
        bus.commitValid   = cv;
        bus.destCommit    = d;
        bus.result        = r;
        bus.commitPC      = pc;
        bus.mispredict    = mp;
        bus.traceReady    = rs ? 1'b0 : rdy;
        bus.clearOverflow = clr;

        mon_en    = known;
        exp_cnt   = model_q.size();
        exp_valid = (exp_cnt != 0);
        exp_ovf   = m_ovf;
        exp_drops = m_drops;
        if (exp_valid) exp_head = model_q[0];

        if (rs) begin
            model_q.delete();
            m_ovf   = 1'b0;
            m_drops = '0;
            known   = 1'b1;
        end else begin
            pop    = exp_valid && rdy;
            accept = cv && (exp_cnt < CAPACITY || pop);
            drop   = cv && !accept;
            if (pop) exp_q.push_back(model_q.pop_front());
            if (accept) model_q.push_back({d, r, pc, mp});
            if (clr) begin
                m_ovf   = drop;
                m_drops = drop ? 16'd1 : 16'd0;
            end else if (drop) begin
                m_ovf = 1'b1;
                if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    task automatic commit(input logic [4:0] d, input logic [31:0] r, input logic [31:0] pc,
                          input logic mp, input logic rdy);
        step(1'b1, d, r, pc, mp, rdy, 1'b0, 1'b0);
    endtask

    // Monitor: compares status every cycle, head while valid, popped entries against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("traceValid", 70'(bus.traceValid), 70'(exp_valid));
            chk("count", 70'(bus.count), 70'(exp_cnt));
            chk("overflow", 70'(bus.overflow), 70'(exp_ovf));
            chk("dropCount", 70'(bus.dropCount), 70'(exp_drops));
            if (exp_valid && bus.traceValid)
                chk("head", {bus.traceDest, bus.traceResult, bus.tracePC, bus.traceFlush}, exp_head);
            if (bus.traceValid && bus.traceReady) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_pop: got pop expected none at %0t", $time);
                end else begin
                    chk("popped_entry",
                        {bus.traceDest, bus.traceResult, bus.tracePC, bus.traceFlush},
                        exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        globalReset = 1'b1;
        bus.commitValid = 1'b0; bus.destCommit = '0; bus.result = '0; bus.commitPC = '0;
        bus.mispredict = 1'b0; bus.traceReady = 1'b0; bus.clearOverflow = 1'b0;

        // Reset, single commit held for 10 cycles, then popped.
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        commit(5'd5, 32'hDEADBEEF, 32'h40, 1'b0, 1'b0);
        idle(10, 1'b0);
        idle(3, 1'b1);

        // 20 back-to-back commits with the reader always ready.
        for (int i = 0; i < 20; i++) commit(5'(i), 32'h1000 + i, 32'(i * 4), 1'b0, 1'b1);
        idle(3, 1'b1);

        // Fill, overfill by 3, drain.
        for (int i = 0; i < 11; i++) commit(5'(i + 1), 32'hA000 + i, 32'h200 + 32'(i * 4), i[0], 1'b0);
        idle(10, 1'b1);

        // Full FIFO with simultaneous commit and pop.
        for (int i = 0; i < 8; i++) commit(5'(i + 9), 32'hB000 + i, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        commit(5'd31, 32'hCAFEF00D, 32'h400, 1'b1, 1'b1);
        idle(10, 1'b1);

        // Drop coinciding with clear, then a clear alone.
        for (int i = 0; i < 8; i++) commit(5'(i), 32'hC000 + i, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
        step(1'b1, 5'd7, 32'h1234, 32'h600, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(10, 1'b1);

        // Five entries queued (head is a mispredict), reset with a commit present, then one commit.
        for (int i = 0; i < 5; i++) commit(5'(i + 2), 32'hD000 + i, 32'h700 + 32'(i * 4), (i == 0), 1'b0);
        idle(2, 1'b0);
        step(1'b1, 5'd9, 32'hBAD, 32'h800, 1'b1, 1'b0, 1'b0, 1'b1);
        commit(5'd3, 32'h600D, 32'h900, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Randomised traffic with varying reader pressure.
        for (int blk = 0; blk < 12; blk++) begin
            int rdy_pct;
            int cv_pct;
            rdy_pct = $urandom_range(0, 100);
            cv_pct  = $urandom_range(30, 100);
            for (int i = 0; i < 50; i++) begin
                step($urandom_range(0, 99) < cv_pct, 5'($urandom), $urandom, $urandom,
                     1'($urandom), $urandom_range(0, 99) < rdy_pct,
                     $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
            end
        end

        idle(20, 1'b1);
        @(posedge clk);
        #6;
        chk("scoreboard_drained", 70'(exp_q.size()), 70'd0);
        chk("fifo_empty", 70'(bus.count), 70'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
